alu_muldiv: RTL and testbench

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_muldiv.sv | 177 +++++++++++++++++
 tb/tb_alu_muldiv.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// alu_muldiv: MIPS-style ALU with zero-latency single-cycle ops plus an
// iterative multiply/divide unit that writes HI/LO after WIDTH cycles.
// Ports: clk, rst (sync, active-high), reg_one/reg_two operands, op funct,
// start launch; result + zero/negative/overflow/carry flags, busy, done, hi, lo.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] reg_one,
    input  logic [WIDTH-1:0] reg_two,
    input  logic [5:0]       op,
    input  logic             start,
    output logic [WIDTH-1:0] result,
    output logic             zero_f,
    output logic             negative_f,
    output logic             overflow_f,
    output logic             carry_f,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;

    logic [SW-1:0]    shamt;
    logic [WIDTH:0]   sum, diff;

    assign shamt = reg_two[SW-1:0];
    assign sum   = {1'b0, reg_one} + {1'b0, reg_two};
    assign diff  = {1'b0, reg_one} + {1'b0, ~reg_two} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        result     = '0;
        carry_f    = 1'b0;
        overflow_f = 1'b0;
        case (op)
            6'd0:  result = reg_one << shamt;
            6'd2:  result = reg_one >> shamt;
            6'd3:  result = $signed(reg_one) >>> shamt;
            6'd8:  result = reg_one;
            6'd16: result = hi;
            6'd18: result = lo;
            6'd32: begin
                result     = sum[WIDTH-1:0];
                carry_f    = sum[WIDTH];
                overflow_f = (reg_one[WIDTH-1] == reg_two[WIDTH-1]) &&
                             (sum[WIDTH-1] != reg_one[WIDTH-1]);
            end
            6'd34: begin
                result     = diff[WIDTH-1:0];
                carry_f    = diff[WIDTH];
                overflow_f = (reg_one[WIDTH-1] != reg_two[WIDTH-1]) &&
                             (diff[WIDTH-1] != reg_one[WIDTH-1]);
            end
            6'd36: result = reg_one & reg_two;
            6'd37: result = reg_one | reg_two;
            6'd38: result = reg_one ^ reg_two;
            6'd39: result = ~(reg_one | reg_two);
            6'd42: result = {{(WIDTH-1){1'b0}},
                             ($signed(reg_one) < $signed(reg_two))};
            6'd43: result = {{(WIDTH-1){1'b0}}, (reg_one < reg_two)};
            default: result = '0;
        endcase
    end

    assign zero_f     = (result == '0);
    assign negative_f = result[WIDTH-1];

    // Launch decode; signed ops (mult/div) have op[0] clear.
    logic             go, sgn_in;
    logic [WIDTH-1:0] a_abs_in, b_abs_in;

    assign go       = start && (op[5:2] == 4'b0110);
    assign sgn_in   = ~op[0];
    assign a_abs_in = (sgn_in && reg_one[WIDTH-1]) ? -reg_one : reg_one;
    assign b_abs_in = (sgn_in && reg_two[WIDTH-1]) ? -reg_two : reg_two;

    // The core always works on magnitudes; signs are reapplied at the end.
    logic [SW-1:0]    cnt;
    logic [WIDTH-1:0] a_lat, b_mag, acc, mq;
    logic             is_div, a_neg, b_neg;

    logic [WIDTH:0]   add_t, sh_t;
    logic             ge;
    logic [WIDTH-1:0] acc_nx, mq_nx;

    always_comb begin
        add_t = mq[0] ? ({1'b0, acc} + {1'b0, b_mag}) : {1'b0, acc};
        sh_t  = {acc, mq[WIDTH-1]};
        ge    = (sh_t >= {1'b0, b_mag});
        if (is_div) begin
            acc_nx = ge ? WIDTH'(sh_t - {1'b0, b_mag}) : sh_t[WIDTH-1:0];
            mq_nx  = {mq[WIDTH-2:0], ge};
        end else begin
            acc_nx = add_t[WIDTH:1];
            mq_nx  = {add_t[0], mq[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   hi_nx, lo_nx;

    always_comb begin
        prod = {acc_nx, mq_nx};
        if (a_neg ^ b_neg)
            prod = -prod;
        if (!is_div) begin
            hi_nx = prod[2*WIDTH-1:WIDTH];
            lo_nx = prod[WIDTH-1:0];
        end else if (b_mag == '0) begin
            hi_nx = a_lat;
            lo_nx = '1;
        end else begin
            hi_nx = a_neg ? -acc_nx : acc_nx;
            lo_nx = (a_neg ^ b_neg) ? -mq_nx : mq_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (go) state_nx = RUN;
            RUN:     if (cnt == LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            a_lat  <= '0;
            b_mag  <= '0;
            acc    <= '0;
            mq     <= '0;
            is_div <= 1'b0;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
        end else if (state == IDLE && go) begin
            cnt    <= '0;
            a_lat  <= reg_one;
            b_mag  <= b_abs_in;
            acc    <= '0;
            mq     <= a_abs_in;
            is_div <= op[1];
            a_neg  <= sgn_in & reg_one[WIDTH-1];
            b_neg  <= sgn_in & reg_two[WIDTH-1];
        end else if (state == RUN) begin
            acc <= acc_nx;
            mq  <= mq_nx;
            cnt <= cnt + SW'(1);
            if (cnt == LAST) begin
                hi <= hi_nx;
                lo <= lo_nx;
            end
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: scoreboard bench driving alu_muldiv at WIDTH 8, 32 and 64
// in lockstep, with expectations from a plain-arithmetic reference model.
module tb_alu_muldiv;
    typedef struct {
        logic [63:0] hi;
        logic [63:0] lo;
    } md_exp_t;

    typedef struct {
        logic [63:0] r;
        logic        z;
        logic        n;
        logic        v;
        logic        c;
    } alu_exp_t;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [5:0]  op;
    logic [63:0] a_in  [3];
    logic [63:0] b_in  [3];
    logic [63:0] res_a [3];
    logic [63:0] hi_a  [3];
    logic [63:0] lo_a  [3];
    logic [2:0]  zf, nf, vf, cf, busy_a, done_a;

    md_exp_t     md_q  [3][$];
    alu_exp_t    alu_q [3][$];
    logic [63:0] mhi [3];
    logic [63:0] mlo [3];
    logic        alu_chk;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 8 : ((g == 1) ? 32 : 64);
        logic [W-1:0] r, h, l;
        alu_muldiv #(.WIDTH(W)) dut (
            .clk(clk), .rst(rst),
            .reg_one(a_in[g][W-1:0]), .reg_two(b_in[g][W-1:0]),
            .op(op), .start(start), .result(r),
            .zero_f(zf[g]), .negative_f(nf[g]),
            .overflow_f(vf[g]), .carry_f(cf[g]),
            .busy(busy_a[g]), .done(done_a[g]), .hi(h), .lo(l)
        );
        assign res_a[g] = 64'(r);
        assign hi_a[g]  = 64'(h);
        assign lo_a[g]  = 64'(l);
    end

    function automatic int wof(input int g);
        return (g == 0) ? 8 : ((g == 1) ? 32 : 64);
    endfunction

    function automatic logic [63:0] msk(input int g);
        return (wof(g) == 64) ? ~64'd0 : ((64'd1 << wof(g)) - 64'd1);
    endfunction

    function automatic logic signed [127:0] sx(input logic [63:0] x,
                                                input int g);
        logic [63:0]  m = msk(g);
        logic [127:0] v = {64'd0, x & m};
        if (x[wof(g)-1])
            v = v | ~{64'd0, m};
        return $signed(v);
    endfunction

    function automatic alu_exp_t alu_ref(input logic [5:0] o,
                                         input logic [63:0] a0,
                                         input logic [63:0] b0,
                                         input int g);
        alu_exp_t e;
        int w = wof(g);
        logic [63:0] m = msk(g);
        logic [63:0] a = a0 & m;
        logic [63:0] b = b0 & m;
        int sh = int'(b & 64'(w - 1));
        logic signed [127:0] sa = sx(a, g);
        logic signed [127:0] sb = sx(b, g);
        logic [127:0] u;
        e.r = 64'd0;
        e.v = 1'b0;
        e.c = 1'b0;
        case (o)
            6'd0:  e.r = (a << sh) & m;
            6'd2:  e.r = a >> sh;
            6'd3:  e.r = 64'(sa >>> sh) & m;
            6'd8:  e.r = a;
            6'd16: e.r = mhi[g];
            6'd18: e.r = mlo[g];
            6'd32: begin
                u   = {64'd0, a} + {64'd0, b};
                e.r = u[63:0] & m;
                e.c = (u > {64'd0, m});
                e.v = ((sa + sb) != sx(e.r, g));
            end
            6'd34: begin
                e.r = (a - b) & m;
                e.c = (a >= b);
                e.v = ((sa - sb) != sx(e.r, g));
            end
            6'd36: e.r = a & b;
            6'd37: e.r = a | b;
            6'd38: e.r = a ^ b;
            6'd39: e.r = ~(a | b) & m;
            6'd42: e.r = (sa < sb) ? 64'd1 : 64'd0;
            6'd43: e.r = (a < b) ? 64'd1 : 64'd0;
            default: e.r = 64'd0;
        endcase
        e.z = (e.r == 64'd0);
        e.n = e.r[w-1];
        return e;
    endfunction

    function automatic md_exp_t md_ref(input logic [5:0] o,
                                       input logic [63:0] a0,
                                       input logic [63:0] b0,
                                       input int g);
        md_exp_t e;
        int w = wof(g);
        logic [63:0] m = msk(g);
        logic [63:0] a = a0 & m;
        logic [63:0] b = b0 & m;
        logic signed [127:0] sa = sx(a, g);
        logic signed [127:0] sb = sx(b, g);
        logic signed [127:0] p;
        logic [127:0] up;
        e.hi = 64'd0;
        e.lo = 64'd0;
        if (o[1] && b == 64'd0) begin
            e.lo = m;
            e.hi = a;
        end else begin
            case (o)
                6'd24: begin
                    p    = sa * sb;
                    e.hi = 64'(p >> w) & m;
                    e.lo = 64'(p) & m;
                end
                6'd25: begin
                    up   = {64'd0, a} * {64'd0, b};
                    e.hi = 64'(up >> w) & m;
                    e.lo = 64'(up) & m;
                end
                6'd26: begin
                    e.lo = 64'(sa / sb) & m;
                    e.hi = 64'(sa % sb) & m;
                end
                default: begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            endcase
        end
        return e;
    endfunction

    function automatic logic [63:0] rnd_val(input int g);
        logic [63:0] m = msk(g);
        logic [63:0] r = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'd1;
            2: return m;
            3: return (m >> 1) + 64'd1;
            4: return m >> 1;
            5: return r & 64'hF;
            default: return r & m;
        endcase
    endfunction

    function automatic logic [5:0] pick_op();
        case ($urandom_range(0, 17))
            0: return 6'd0;
            1: return 6'd2;
            2: return 6'd3;
            3: return 6'd8;
            4: return 6'd32;
            5: return 6'd34;
            6: return 6'd36;
            7: return 6'd37;
            8: return 6'd38;
            9: return 6'd39;
            10: return 6'd42;
            11: return 6'd43;
            12: return 6'd16;
            13: return 6'd18;
            14: return 6'd24 + 6'($urandom_range(0, 3));
            15: return 6'd33;
            16: return 6'd1;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    md_exp_t  me;
    alu_exp_t ae;

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (done_a[g]) begin
                if (md_q[g].size() == 0) begin
                    n_chk++;
                    $display("FAIL w%0d_spurious_done: got 1 want 0", wof(g));
                end else begin
                    me = md_q[g].pop_front();
                    chk($sformatf("w%0d_hi", wof(g)), hi_a[g], me.hi);
                    chk($sformatf("w%0d_lo", wof(g)), lo_a[g], me.lo);
                    mhi[g] = me.hi;
                    mlo[g] = me.lo;
                end
            end
            if (alu_chk && alu_q[g].size() != 0) begin
                ae = alu_q[g].pop_front();
                chk($sformatf("w%0d_op%0d_res", wof(g), op), res_a[g], ae.r);
                chk($sformatf("w%0d_op%0d_zn_vc", wof(g), op),
                    {60'd0, zf[g], nf[g], vf[g], cf[g]},
                    {60'd0, ae.z, ae.n, ae.v, ae.c});
            end
        end
        alu_chk = 1'b0;
    end

    task automatic alu_op(input logic [5:0] o);
        op = o;
        for (int g = 0; g < 3; g++)
            alu_q[g].push_back(alu_ref(o, a_in[g], b_in[g], g));
        alu_chk = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_md(input logic [5:0] o, input int rst_at,
                          input bit poke);
        int dl [3];
        int bc [3];
        int dc [3];
        logic [63:0] old_hi [3];
        for (int g = 0; g < 3; g++) begin
            dl[g] = 0;
            bc[g] = 0;
            dc[g] = 0;
            old_hi[g] = mhi[g];
            if (rst_at == 0 || wof(g) + 1 < rst_at)
                md_q[g].push_back(md_ref(o, a_in[g], b_in[g], g));
        end
        op = o;
        start = 1'b1;
        for (int k = 1; k <= 67; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            for (int g = 0; g < 3; g++) begin
                if (done_a[g]) begin
                    dc[g]++;
                    if (dl[g] == 0) dl[g] = k;
                end
                if (busy_a[g]) bc[g]++;
            end
            if (k == rst_at) begin
                rst = 1'b0;
                for (int g = 0; g < 3; g++) begin
                    chk($sformatf("w%0d_abort_busy", wof(g)),
                        {63'd0, busy_a[g]}, 64'd0);
                    chk($sformatf("w%0d_abort_hi", wof(g)), hi_a[g], 64'd0);
                    chk($sformatf("w%0d_abort_lo", wof(g)), lo_a[g], 64'd0);
                    mhi[g] = 64'd0;
                    mlo[g] = 64'd0;
                end
            end
            for (int g = 0; g < 3; g++) begin
                a_in[g] = rnd_val(g);
                b_in[g] = rnd_val(g);
            end
            op = 6'($urandom_range(0, 63));
            if (k + 1 == rst_at) rst = 1'b1;
            if (poke && k == 3) begin
                op = 6'd24 + 6'($urandom_range(0, 3));
                start = 1'b1;
            end
            if (k == 5) begin
                op = 6'd16;
                #1;
                for (int g = 0; g < 3; g++)
                    chk($sformatf("w%0d_mfhi_in_run", wof(g)),
                        res_a[g], old_hi[g]);
            end
        end
        for (int g = 0; g < 3; g++) begin
            if (rst_at != 0 && wof(g) + 1 >= rst_at) begin
                chk($sformatf("w%0d_abort_dones", wof(g)), 64'(dc[g]), 64'd0);
            end else begin
                chk($sformatf("w%0d_done_edge", wof(g)),
                    64'(dl[g]), 64'(wof(g) + 1));
                chk($sformatf("w%0d_busy_cycles", wof(g)),
                    64'(bc[g]), 64'(wof(g)));
                chk($sformatf("w%0d_done_pulses", wof(g)), 64'(dc[g]), 64'd1);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b1;
        op = 6'd24;
        alu_chk = 1'b0;
        for (int g = 0; g < 3; g++) begin
            a_in[g] = msk(g);
            b_in[g] = 64'd1;
            mhi[g] = 64'd0;
            mlo[g] = 64'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("w%0d_rst_busy", wof(g)), {63'd0, busy_a[g]}, 64'd0);
            chk($sformatf("w%0d_rst_done", wof(g)), {63'd0, done_a[g]}, 64'd0);
            chk($sformatf("w%0d_rst_hi", wof(g)), hi_a[g], 64'd0);
            chk($sformatf("w%0d_rst_lo", wof(g)), lo_a[g], 64'd0);
        end
        rst = 1'b0;
        start = 1'b0;

        alu_op(6'd16);
        chk("w32_mfhi_after_rst", res_a[1], 64'd0);
        chk("w32_mfhi_zero_f", {63'd0, zf[1]}, 64'd1);

        for (int g = 0; g < 3; g++) begin
            a_in[g] = msk(g) >> 1;
            b_in[g] = 64'd1;
        end
        alu_op(6'd32);
        chk("w32_add_ovf_res", res_a[1], 64'h8000_0000);
        chk("w32_add_vnc", {61'd0, vf[1], nf[1], cf[1]}, 64'b110);

        for (int g = 0; g < 3; g++) begin
            a_in[g] = msk(g);
            b_in[g] = msk(g);
        end
        run_md(6'd25, 0, 1'b0);
        chk("w32_multu_hi", hi_a[1], 64'hFFFF_FFFE);
        chk("w32_multu_lo", lo_a[1], 64'h0000_0001);

        for (int g = 0; g < 3; g++) begin
            a_in[g] = (64'd0 - 64'd3) & msk(g);
            b_in[g] = 64'd5;
        end
        run_md(6'd24, 0, 1'b0);
        chk("w32_mult_hi", hi_a[1], 64'hFFFF_FFFF);
        chk("w32_mult_lo", lo_a[1], 64'hFFFF_FFF1);

        for (int g = 0; g < 3; g++) begin
            a_in[g] = (64'd0 - 64'd7) & msk(g);
            b_in[g] = 64'd2;
        end
        run_md(6'd26, 0, 1'b0);
        chk("w32_div_lo", lo_a[1], 64'hFFFF_FFFD);
        chk("w32_div_hi", hi_a[1], 64'hFFFF_FFFF);

        for (int g = 0; g < 3; g++) begin
            a_in[g] = 64'd7;
            b_in[g] = 64'd0;
        end
        run_md(6'd27, 0, 1'b0);
        chk("w32_divu0_lo", lo_a[1], 64'hFFFF_FFFF);
        chk("w32_divu0_hi", hi_a[1], 64'h0000_0007);

        for (int g = 0; g < 3; g++) begin
            a_in[g] = (64'd0 - 64'd7) & msk(g);
            b_in[g] = 64'd0;
        end
        run_md(6'd26, 0, 1'b0);

        for (int g = 0; g < 3; g++) begin
            a_in[g] = (msk(g) >> 1) + 64'd1;
            b_in[g] = msk(g);
        end
        run_md(6'd26, 0, 1'b0);
        chk("w32_min_div_m1_lo", lo_a[1], 64'h8000_0000);
        chk("w32_min_div_m1_hi", hi_a[1], 64'd0);
        alu_op(6'd16);
        alu_op(6'd18);

        for (int g = 0; g < 3; g++) begin
            a_in[g] = rnd_val(g);
            b_in[g] = rnd_val(g);
        end
        run_md(6'd24 + 6'($urandom_range(0, 3)), 0, 1'b1);

        for (int g = 0; g < 3; g++) begin
            a_in[g] = rnd_val(g);
            b_in[g] = rnd_val(g);
        end
        run_md(6'd25, 11, 1'b0);
        alu_op(6'd16);
        alu_op(6'd18);

        repeat (60) begin
            for (int g = 0; g < 3; g++) begin
                a_in[g] = rnd_val(g);
                b_in[g] = rnd_val(g);
            end
            if ($urandom_range(0, 3) == 0)
                run_md(6'd24 + 6'($urandom_range(0, 3)), 0, 1'b0);
            else
                alu_op(pick_op());
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
